// File: rtl/nibble_serial_addsub_pkg.sv
// Shared definitions for the LC-3 sequential datapath helpers.
//   state_t   : FSM state encoding for the serial add/subtract unit
//   NIBBLE_W  : width of one adder slice
//   idx_width : nibble-index register width for a given slice count
package lc3_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NIBBLE_W = 4;

  // A single-slice build still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Request/result bundle between the control unit and nibble_serial_addsub.
//   Start, Sub, A, B        : request side (driven by master)
//   Sum, Cout, Ovf, Busy, Done : result side (driven by slave)
interface nibble_serial_addsub_if #(
  parameter int unsigned W = 16
);

  logic         Start;
  logic         Sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;
  logic         Busy;
  logic         Done;

  modport master (
    output Start, Sub, A, B,
    input  Sum, Cout, Ovf, Busy, Done
  );

  modport slave (
    input  Start, Sub, A, B,
    output Sum, Cout, Ovf, Busy, Done
  );

endinterface

// File: rtl/fourbit_adder.sv
// Purely combinational 4-bit ripple-carry adder.
//   i_a, i_b : addends
//   i_cin    : carry in
//   o_s      : 4-bit sum
//   o_cout   : carry out of the top bit
module fourbit_adder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_s,
  output logic       o_cout
);

  logic [4:0] w_c;

  always_comb begin
    w_c    = '0;
    o_s    = '0;
    w_c[0] = i_cin;
    for (int unsigned i = 0; i < 4; i++) begin
      o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c[4];
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle W-bit add/subtract unit sharing one 4-bit ripple adder across
// NIBBLES slices, least significant slice first.
//   Clk, Reset : clock, synchronous active-high reset
//   bus.Start  : request, accepted in IDLE or DONE
//   bus.Sub    : 0 = A+B, 1 = A-B (latched with operands)
//   bus.A/B    : operands, latched on accepted Start
//   bus.Sum    : result register (partial during RUN)
//   bus.Cout   : final carry out (subtract: 1 = no borrow)
//   bus.Ovf    : two's-complement overflow
//   bus.Busy   : high in RUN and DONE
//   bus.Done   : one-cycle pulse, results valid while high
module nibble_serial_addsub
  import lc3_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  nibble_serial_addsub_if.slave  bus
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic                r_carry;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic                r_sub;
  logic [W-1:0]        r_sum;
  logic                r_cout;
  logic                r_ovf;
  logic                r_busy;
  logic                r_done;

  logic [NIBBLE_W-1:0] w_x;
  logic [NIBBLE_W-1:0] w_y;
  logic [NIBBLE_W-1:0] w_s;
  logic                w_co;
  logic                w_accept;

  // Subtraction is A + ~B + 1: invert B per slice, the +1 comes from the
  // carry register being preset to Sub on acceptance.
  always_comb begin
    w_x = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    w_y = r_b[r_idx*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{r_sub}};
  end

  fourbit_adder u_adder (
    .i_a    (w_x),
    .i_b    (w_y),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_co)
  );

  assign w_accept = bus.Start && ((r_state == IDLE) || (r_state == DONE));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_sub   <= bus.Sub;
            r_carry <= bus.Sub;
            r_sum   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_sum[r_idx*NIBBLE_W +: NIBBLE_W] <= w_s;
          r_carry <= w_co;
          if (r_idx == LAST_IDX) begin
            // Top slice: sign bits come straight from this slice's adder
            // inputs/outputs since Sum's MSB is being written this edge.
            r_cout  <= w_co;
            r_ovf   <= (r_a[W-1] == w_y[NIBBLE_W-1]) &&
                       (w_s[NIBBLE_W-1] != r_a[W-1]);
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Sum  = r_sum;
  assign bus.Cout = r_cout;
  assign bus.Ovf  = r_ovf;
  assign bus.Busy = r_busy;
  assign bus.Done = r_done;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub (NIBBLES = 4).
module tb_nibble_serial_addsub;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned done_cnt = 0;
  exp_t        sb_q[$];

  always #5 clk = ~clk;

  nibble_serial_addsub_if #(.W(16)) bus ();

  nibble_serial_addsub #(.NIBBLES(4)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
    logic [16:0] r;
    exp_t e;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + 17'd1;
    else     r = {1'b0, a} + {1'b0, b};
    e.sum  = r[15:0];
    e.cout = r[16];
    if (sub) e.ovf = (a[15] != b[15]) && (r[15] != a[15]);
    else     e.ovf = (a[15] == b[15]) && (r[15] != a[15]);
    return e;
  endfunction

  // Scoreboard: every Done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.Done) begin
      exp_t e;
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sum",  32'(bus.Sum),  32'(e.sum));
        check("cout", 32'(bus.Cout), 32'(e.cout));
        check("ovf",  32'(bus.Ovf),  32'(e.ovf));
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub, input string tag);
    int unsigned lat;
    int unsigned busy_n;
    bit seen;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.Sub = sub; bus.Start = 1'b1;
    sb_q.push_back(model(a, b, sub));
    @(posedge clk);
    #1;
    bus.Start = 1'b0; bus.A = ~a; bus.B = ~b; bus.Sub = ~sub;
    seen = 0; lat = 0; busy_n = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.Busy) busy_n++;
      if (bus.Done) seen = 1;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, lat, 32'd5);
      @(negedge clk);
      check({tag, "_busy_cycles"}, busy_n, 32'd5);
      check({tag, "_idle_after"}, 32'(bus.Busy), 32'd0);
    end
  endtask

  initial begin
    bus.Start = 1'b0; bus.Sub = 1'b0; bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_sum",  32'(bus.Sum),  32'd0);
    check("rst_cout", 32'(bus.Cout), 32'd0);
    check("rst_ovf",  32'(bus.Ovf),  32'd0);
    rst = 1'b0;

    run_op(16'h1234, 16'h0FCD, 1'b0, "add");
    run_op(16'hFFFF, 16'h0001, 1'b0, "ripple");
    run_op(16'h7FFF, 16'h0001, 1'b0, "ovf_add");
    run_op(16'h0005, 16'h0007, 1'b1, "sub_borrow");
    run_op(16'h8000, 16'h0001, 1'b1, "ovf_sub");

    // Start held high; only operands at accepting edges (every 5th) matter.
    @(negedge clk);
    bus.Start = 1'b1;
    for (int k = 0; k < 15; k++) begin
      bus.A   = 16'($urandom);
      bus.B   = 16'($urandom);
      bus.Sub = 1'($urandom);
      if (k % 5 == 0) sb_q.push_back(model(bus.A, bus.B, bus.Sub));
      @(posedge clk);
      @(negedge clk);
      check("b2b_done", 32'(bus.Done), (k % 5 == 4) ? 32'd1 : 32'd0);
    end
    bus.Start = 1'b0;
    @(negedge clk);
    check("b2b_idle", 32'(bus.Busy), 32'd0);

    // Reset in the 2nd RUN cycle aborts without a Done pulse.
    begin
      int unsigned d0;
      bus.A = 16'h1111; bus.B = 16'h2222; bus.Sub = 1'b0; bus.Start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.Start = 1'b0;
      @(negedge clk);
      check("abort_partial_sum", 32'(bus.Sum), 32'h0003);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(bus.Busy), 32'd0);
      check("abort_done", 32'(bus.Done), 32'd0);
      check("abort_sum",  32'(bus.Sum),  32'd0);
      d0 = done_cnt;
      repeat (8) @(negedge clk);
      check("abort_no_done", done_cnt, d0);
    end
    run_op(16'hABCD, 16'h1357, 1'b1, "post_abort");

    // Reset dominates Start on the same edge.
    @(negedge clk);
    bus.A = 16'h0001; bus.B = 16'h0001; bus.Sub = 1'b0;
    bus.Start = 1'b1; rst = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0; rst = 1'b0;
    check("rst_start_busy", 32'(bus.Busy), 32'd0);
    @(negedge clk);
    check("rst_start_busy2", 32'(bus.Busy), 32'd0);
    check("rst_start_done",  32'(bus.Done), 32'd0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Multi-cycle 16-bit add/subtract unit that time-shares one 4-bit ripple adder (fourbit_adder) across four nibbles, least significant nibble first.
- A small FSM sequences the nibbles, carries the inter-nibble carry in a register, and assembles the result.
- Intended for area-constrained LC-3 datapath variants, where a single narrow adder replaces a full-width ALU adder.
- Start/Done handshake toward the control unit.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; clears all state.
- Start  in  1  request; sampled only when the unit is idle or in DONE.
- Sub  in  1  0 = A+B, 1 = A-B; latched with the operands.
- A  in  W  operand A; latched on an accepted Start.
- B  in  W  operand B; latched on an accepted Start.
- Sum  out  W  result register; holds its value until the next accepted Start.
- Cout  out  1  final carry out (for Sub = 1: 1 = no borrow).
- Ovf  out  1  two's-complement overflow.
- Busy  out  1  high in RUN and DONE states.
- Done  out  1  one-cycle pulse; Sum, Cout and Ovf are valid while it is high.

Behaviour:
- Reset values: state IDLE, idx 0, carry register 0, Sum 0, Cout 0, Ovf 0, Busy 0, Done 0.
- Reset dominates Start on the same edge. Reset mid-operation aborts the operation, returns to IDLE, and clears Sum with no Done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start=1 at edge E0: latch A, B and Sub; set the carry register to Sub; clear Sum; set idx to 0; go to RUN.
  - Start=0: remain in IDLE.
- RUN, each edge:
  - Adder inputs: x = A_reg nibble[idx], y = (B_reg nibble[idx] XOR {4{Sub_reg}}), carry-in = carry register.
  - Write the adder sum into Sum nibble[idx]; the carry register takes the adder carry-out; idx increments.
  - When idx = NIBBLES-1 is processed: Cout takes the adder carry-out, Ovf is computed, go to DONE.
  - Start is ignored throughout RUN.
- Ovf = (A_reg[W-1] == B'[W-1]) AND (Sum[W-1] != A_reg[W-1]), where B' is the inverted B when Sub = 1. It is computed from the final nibble's values in the same edge in which that nibble is written.
- Latency: the Start sampled at E0 gives writes at E1..E4 (for NIBBLES = 4). DONE holds during the cycle after E4; Done=1 in that cycle only.
- DONE:
  - Start=1: behaves exactly as an accepted Start in IDLE, so back-to-back operations are allowed with no idle gap (next Done 5 cycles later).
  - Start=0: go to IDLE.
- Throughput: one operation per NIBBLES+1 cycles.
- Partial Sum nibbles are visible during RUN and are not valid until Done.
- Operand inputs A, B and Sub may change freely after the accepting edge.
- Busy = (state != IDLE).
- idx wraps only through re-initialisation on Start; it never wraps within RUN.

Decomposition:
- Shared package lc3_seq_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the constant NIBBLE_W = 4;
  - an idx width derived as $clog2(NIBBLES).
- The sub-module is the existing fourbit_adder, instantiated once, purely combinational. Nibble select muxes, the B inversion and all registers live in nibble_serial_addsub.

Test Plan:
- Add, no carry: A=0x1234, B=0x0FCD, Sub=0, Start for 1 cycle -> Done exactly 5 cycles after the Start edge; Sum=0x2201, Cout=0, Ovf=0; Busy high for 5 cycles.
- Full carry ripple: A=0xFFFF, B=0x0001, Sub=0 -> Sum=0x0000, Cout=1, Ovf=0. Signed overflow: A=0x7FFF, B=0x0001 -> Sum=0x8000, Ovf=1, Cout=0.
- Subtract: A=0x0005, B=0x0007, Sub=1 -> Sum=0xFFFE, Cout=0, Ovf=0. Then A=0x8000, B=0x0001, Sub=1 -> Sum=0x7FFF, Cout=1, Ovf=1.
- Start held high continuously with operands changed every cycle -> only operands present at the accepting edges (IDLE, then each DONE cycle) are used; Done pulses every 5 cycles; mid-RUN changes have no effect.
- Reset asserted at the 2nd RUN cycle -> next cycle: Busy=0, Done=0, Sum=0x0000; no Done pulse follows. A new Start afterwards completes correctly.
- Start and Reset high on the same edge -> remains in IDLE, Busy=0.
